// File: rtl/au_pipe.sv
// Two-stage pipelined add/sub/paddsw arithmetic unit with valid/ready on both sides.
// S1 registers the request, S2 registers the computed result and flags.
module au_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_err,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int LANES = WIDTH / 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PADD = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  op_e              s1_op_q, s1_op_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_cout_q, s2_cout_d;
  logic             s2_ovf_q, s2_ovf_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic in_fire, out_fire, s2_load;
  logic unused_cmd_bits;

  assign unused_cmd_bits = ^{in_cmd[2], in_cmd[0]};

  assign in_ready = !s1_valid_q || !s2_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);

  // ADD and SUB share one adder: SUB is A + ~B + 1.
  logic             is_sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   arith;
  logic             arith_ovf;

  assign is_sub    = (s1_op_q == OP_SUB);
  assign b_x       = is_sub ? ~s1_b_q : s1_b_q;
  assign arith     = {1'b0, s1_a_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, is_sub};
  assign arith_ovf = (s1_a_q[WIDTH-1] == b_x[WIDTH-1]) &&
                     (arith[WIDTH-1] != s1_a_q[WIDTH-1]);

  logic [WIDTH-1:0] padd;
  logic [LANES-1:0] lane_sat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [4:0] lsum;
    assign lsum        = {s1_a_q[4*g+3], s1_a_q[4*g +: 4]} +
                         {s1_b_q[4*g+3], s1_b_q[4*g +: 4]};
    // A 5-bit signed sum whose top two bits disagree does not fit in 4 bits.
    assign lane_sat[g] = lsum[4] ^ lsum[3];
    assign padd[4*g +: 4] = lane_sat[g] ? (lsum[4] ? 4'h8 : 4'h7) : lsum[3:0];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_cout_d   = s2_cout_q;
    s2_ovf_d    = s2_ovf_q;
    s2_err_d    = s2_err_q;
    done_cnt_d  = done_cnt_q + {{(CNT_W-1){1'b0}}, out_fire};

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op_e'({in_cmd[3], in_cmd[1]});
      s1_a_d     = in_a;
      s1_b_d     = in_b;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      unique case (s1_op_q)
        OP_ADD, OP_SUB: begin
          s2_result_d = arith[WIDTH-1:0];
          s2_cout_d   = arith[WIDTH];
          s2_ovf_d    = arith_ovf;
          s2_err_d    = 1'b0;
        end
        OP_PADD: begin
          s2_result_d = padd;
          s2_cout_d   = 1'b0;
          s2_ovf_d    = |lane_sat;
          s2_err_d    = 1'b0;
        end
        default: begin
          s2_result_d = '0;
          s2_cout_d   = 1'b0;
          s2_ovf_d    = 1'b0;
          s2_err_d    = 1'b1;
        end
      endcase
    end else if (out_fire) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_cout_q   <= 1'b0;
      s2_ovf_q    <= 1'b0;
      s2_err_q    <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_cout_q   <= s2_cout_d;
      s2_ovf_q    <= s2_ovf_d;
      s2_err_q    <= s2_err_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_cout   = s2_cout_q;
  assign out_ovf    = s2_ovf_q;
  assign out_err    = s2_err_q;
  assign done_cnt   = done_cnt_q;

endmodule
